uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of uart_tx.
- Deserialises frames of 1 start bit (0), 8 data bits LSB first, an optional parity bit, and 1 stop bit (1). Line idles high.
- Presents each received byte with a single-cycle valid pulse plus parity and framing status.
- Sits at the serial input of the UART block, with rx driven by a uart_tx output or an external pin.

Parameters:
- CLKS_PER_BIT, 1, clock cycles per serial bit; legal values >=1. A value of 1 matches uart_tx line timing.
- HALF_BIT, (CLKS_PER_BIT-1)/2, mid-bit sample offset; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  serial line; idle high.
- parity_en  input  1  1 = frame carries a parity bit.
- even_parity  input  1  parity mode select; same encoding as uart_tx.
- data_out  output  8  last received byte.
- rx_valid  output  1  one-cycle pulse when a frame completes.
- parity_err  output  1  parity mismatch; qualified by rx_valid.
- frame_err  output  1  stop bit sampled 0; qualified by rx_valid.
- rx_busy  output  1  frame reception in progress.

Behaviour:
- Reset: rst is synchronous and active-high on clk. Reset state is IDLE. data_out=0x00; rx_valid, parity_err, frame_err and rx_busy all 0. All counters clear.
- rx_s is the internal line sample. It equals rx, or the synchronised rx when the optional feature is enabled.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE -> frame begins: t0 is the first cycle in IDLE with rx_s==0. At t0 the block latches parity_en and even_parity. Later changes to these inputs are ignored until the next frame.
- Sample times: bit k (k=0 is the start bit) is sampled at cycle t0 + k*CLKS_PER_BIT + HALF_BIT.
- Start check: the start bit is re-checked at its sample point.
  - rx_s==1 there means a glitch: return to IDLE with no outputs.
  - When HALF_BIT==0, the t0 sample is the start check.
- DATA: 8 samples, LSB first, shifted into a holding register.
- PARITY: entered only if the latched parity_en==1.
  - Expected bit = (^data) when latched even_parity==0; ~(^data) when latched even_parity==1.
  - Mismatch sets the parity error.
- Frame length: nbits = 11 with parity, 10 without.
- STOP: sampled at bit index nbits-1.
- Completion: on the cycle after the stop sample:
  - rx_valid=1 for exactly one cycle.
  - data_out is updated and then held until the next rx_valid.
  - parity_err and frame_err are updated; both are forced to 0 when their checks do not apply.
  - rx_valid pulses even when an error flag is set.
- Next frame: after a good stop bit, return to IDLE. A start can be detected on the cycle immediately following the stop sample, so back-to-back frames are supported.
- Stop bit 0 (frame error / break): after the completion pulse, enter BREAK. Remain in BREAK until rx_s==1, then go to IDLE. No new frame is detected while rx stays low.
- rx_busy: 1 from t0 through the stop-sample cycle, and 1 while in BREAK. 0 otherwise.
- Reset mid-frame: abort immediately, with no rx_valid. The next frame requires a fresh falling edge seen from IDLE.
- Counters:
  - clk_cnt is wide enough for CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - bit_idx runs 0..nbits-1.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: rx passes through a two-flop synchroniser.
  - Both flops reset to 1.
  - rx_s lags rx by 2 cycles, so every timing point above shifts by +2 cycles relative to rx.
- Undefined: rx_s = rx combinationally, with no added latency.

Test Plan:
- CLKS_PER_BIT=1, macro off, parity_en=1, even_parity=1. Drive 0xA5 as 0,1,0,1,0,0,1,0,1, then parity 1, then stop 1.
  -> rx_valid pulses the cycle after the stop bit; data_out=0xA5; parity_err=0; frame_err=0.
- CLKS_PER_BIT=1, parity_en=0. Drive 0x3C followed immediately by a second frame with 0xFF and no idle gap.
  -> two rx_valid pulses 10 cycles apart; data_out=0x3C, then 0xFF; no errors.
- Same as test 1 but with the parity bit driven 0.
  -> rx_valid=1, data_out=0xA5, parity_err=1, frame_err=0.
- CLKS_PER_BIT=1, parity_en=0, data 0x55, stop bit driven 0 and rx held low for 5 more cycles.
  -> rx_valid with frame_err=1; rx_busy stays 1 until rx returns high; no spurious second frame.
- CLKS_PER_BIT=16. rx low for 3 cycles, then high.
  -> no rx_valid; returns to IDLE with rx_busy=0 by cycle t0+8.
  - Follow with a full 0x81 frame -> data_out=0x81.
- CLKS_PER_BIT=1. Assert rst for 1 cycle after data bit 3 of a frame.
  -> no rx_valid, all outputs 0, rx_busy=0. The next complete frame (0x12) is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: UART receiver for 1 start bit, 8 data bits LSB first, optional parity and 1 stop bit.
// Define UART_RX_SYNC_EN to put rx through a two-flop synchroniser (adds 2 cycles of latency).
module uart_rx #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       parity_en,
   input  logic       even_parity,
   output logic [7:0] data_out,
   output logic       rx_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
   localparam int CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_CNT = CW'(HALF_BIT);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);
   localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   // even_mode=1 selects the inverted reduction, matching the transmitter's encoding
   function automatic logic parity_bit(input logic [7:0] data, input logic even_mode);
      return even_mode ? ~(^data) : (^data);
   endfunction

   logic rx_s;

`ifdef UART_RX_SYNC_EN
   logic [1:0] sync_q;

   // two-flop synchroniser, idles high out of reset
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx};
      end
   end

   assign rx_s = sync_q[1];
`else
   assign rx_s = rx;
`endif

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_en_q, par_en_d;
   logic          even_q, even_d;
   logic          perr_q, perr_d;
   logic          armed_q, armed_d;
   logic [7:0]    dout_q, dout_d;
   logic          valid_q, valid_d;
   logic          parity_err_q, parity_err_d;
   logic          frame_err_q, frame_err_d;

   // state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= ZERO_CNT;
         idx_q        <= 4'd0;
         shift_q      <= 8'h00;
         par_en_q     <= 1'b0;
         even_q       <= 1'b0;
         perr_q       <= 1'b0;
         armed_q      <= 1'b0;
         dout_q       <= 8'h00;
         valid_q      <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         par_en_q     <= par_en_d;
         even_q       <= even_d;
         perr_q       <= perr_d;
         armed_q      <= armed_d;
         dout_q       <= dout_d;
         valid_q      <= valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // next-state logic; armed_q requires a high line before a start, so a start needs a real falling edge
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      shift_d      = shift_q;
      par_en_d     = par_en_q;
      even_d       = even_q;
      perr_d       = perr_q;
      armed_d      = rx_s;
      dout_d       = dout_q;
      valid_d      = 1'b0;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;

      case (state_q)
         S_IDLE: begin
            if (armed_q && !rx_s) begin
               par_en_d = parity_en;
               even_d   = even_parity;
               perr_d   = 1'b0;
               if (HALF_BIT == 0) begin
                  state_d = S_DATA;
                  cnt_d   = ZERO_CNT;
                  idx_d   = 4'd1;
               end else begin
                  state_d = S_START;
                  cnt_d   = ONE_CNT;
                  idx_d   = 4'd0;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (cnt_q == HALF_CNT) begin
               if (rx_s) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
                  cnt_d   = ZERO_CNT;
                  idx_d   = 4'd1;
               end
            end else begin
               cnt_d = cnt_q + ONE_CNT;
            end
         end
         S_DATA: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d   = ZERO_CNT;
               shift_d = {rx_s, shift_q[7:1]};
               idx_d   = idx_q + 4'd1;
               if (idx_q == 4'd8) begin
                  state_d = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  state_d = S_DATA;
               end
            end else begin
               cnt_d = cnt_q + ONE_CNT;
            end
         end
         S_PARITY: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d   = ZERO_CNT;
               perr_d  = rx_s ^ parity_bit(shift_q, even_q);
               idx_d   = idx_q + 4'd1;
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + ONE_CNT;
            end
         end
         S_STOP: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d        = ZERO_CNT;
               idx_d        = 4'd0;
               valid_d      = 1'b1;
               dout_d       = shift_q;
               parity_err_d = par_en_q & perr_q;
               frame_err_d  = ~rx_s;
               state_d      = rx_s ? S_IDLE : S_BREAK;
            end else begin
               cnt_d = cnt_q + ONE_CNT;
            end
         end
         S_BREAK: begin
            state_d = rx_s ? S_IDLE : S_BREAK;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // busy must cover t0 itself, so the start condition is included combinationally
   assign rx_busy    = (state_q != S_IDLE) || (armed_q && !rx_s);
   assign data_out   = dout_q;
   assign rx_valid   = valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames into two uart_rx instances (1 and 16 clocks per bit),
// checked against a frame-level model of expected completion cycle, byte and error flags.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int CPB_A = 1;
   localparam int CPB_B = 16;
`ifdef UART_RX_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_a, rx_b;
   logic       parity_en, even_parity;
   logic [7:0] dout_a, dout_b;
   logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b, busy_a, busy_b;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   typedef struct {
      int         cyc;
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } evt_t;

   evt_t obs_a[$], obs_b[$], exp_a[$], exp_b[$];

   uart_rx #(.CLKS_PER_BIT(CPB_A)) u_dut_a (
      .clk(clk), .rst(rst), .rx(rx_a), .parity_en(parity_en), .even_parity(even_parity),
      .data_out(dout_a), .rx_valid(valid_a), .parity_err(perr_a), .frame_err(ferr_a),
      .rx_busy(busy_a)
   );

   uart_rx #(.CLKS_PER_BIT(CPB_B)) u_dut_b (
      .clk(clk), .rst(rst), .rx(rx_b), .parity_en(parity_en), .even_parity(even_parity),
      .data_out(dout_b), .rx_valid(valid_b), .parity_err(perr_b), .frame_err(ferr_b),
      .rx_busy(busy_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // record every completion pulse with its cycle number
   always @(negedge clk) begin
      evt_t e;
      if (valid_a === 1'b1) begin
         e.cyc = cyc; e.data = dout_a; e.perr = perr_a; e.ferr = ferr_a;
         obs_a.push_back(e);
      end
      if (valid_b === 1'b1) begin
         e.cyc = cyc; e.data = dout_b; e.perr = perr_b; e.ferr = ferr_b;
         obs_b.push_back(e);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
         $error("check %s miscompared", tag);
      end
   endtask

   task automatic drive(input int sel, input logic b);
      @(posedge clk);
      #1;
      if (sel == 0) rx_a = b;
      else          rx_b = b;
   endtask

   task automatic hold(input int sel, input logic b, input int n);
      for (int i = 0; i < n; i++) drive(sel, b);
   endtask

   // drive one whole frame and predict its completion from the frame rules
   task automatic send_frame(input int sel, input logic [7:0] data, input logic pe,
                             input logic ep, input logic pbit, input logic stop);
      int          cpb, half, nb, t0;
      logic [10:0] bits;
      evt_t        e;
      cpb  = (sel == 0) ? CPB_A : CPB_B;
      half = (cpb - 1) / 2;
      nb   = pe ? 11 : 10;
      bits = 11'h7FF;
      bits[0]   = 1'b0;
      bits[8:1] = data;
      if (pe) begin
         bits[9]  = pbit;
         bits[10] = stop;
      end else begin
         bits[9]  = stop;
      end
      parity_en   = pe;
      even_parity = ep;
      t0 = -1;
      for (int k = 0; k < nb; k++) begin
         for (int c = 0; c < cpb; c++) begin
            drive(sel, bits[k]);
            if (t0 < 0) t0 = cyc;
            if (cyc == t0 + LAT + 1) begin
               parity_en   = 1'($urandom_range(0, 1));
               even_parity = 1'($urandom_range(0, 1));
            end
         end
      end
      e.cyc  = t0 + LAT + (nb - 1) * cpb + half + 1;
      e.data = data;
      e.perr = pe ? (pbit != (ep ? ~(^data) : (^data))) : 1'b0;
      e.ferr = ~stop;
      if (sel == 0) exp_a.push_back(e);
      else          exp_b.push_back(e);
   endtask

   task automatic compare_events(input int sel, input string tag);
      evt_t o, x;
      int   n_obs, n_exp;
      n_obs = (sel == 0) ? obs_a.size() : obs_b.size();
      n_exp = (sel == 0) ? exp_a.size() : exp_b.size();
      check($sformatf("%s.count", tag), 32'(n_obs), 32'(n_exp));
      for (int i = 0; i < n_exp && i < n_obs; i++) begin
         if (sel == 0) begin
            o = obs_a.pop_front(); x = exp_a.pop_front();
         end else begin
            o = obs_b.pop_front(); x = exp_b.pop_front();
         end
         check($sformatf("%s[%0d].cyc", tag, i), 32'(o.cyc), 32'(x.cyc));
         check($sformatf("%s[%0d].data", tag, i), 32'(o.data), 32'(x.data));
         check($sformatf("%s[%0d].perr", tag, i), 32'(o.perr), 32'(x.perr));
         check($sformatf("%s[%0d].ferr", tag, i), 32'(o.ferr), 32'(x.ferr));
      end
      obs_a.delete(); obs_b.delete(); exp_a.delete(); exp_b.delete();
   endtask

   initial begin
      logic [7:0] d, part;
      logic       pe, ep, pb, st;
      int         gap;

      rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; parity_en = 1'b0; even_parity = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst.dout_a", 32'(dout_a), 32'h00);
      check("rst.valid_a", 32'(valid_a), 32'h0);
      check("rst.perr_a", 32'(perr_a), 32'h0);
      check("rst.ferr_a", 32'(ferr_a), 32'h0);
      check("rst.busy_a", 32'(busy_a), 32'h0);
      check("rst.dout_b", 32'(dout_b), 32'h00);
      check("rst.busy_b", 32'(busy_b), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      hold(0, 1'b1, 3);
      @(negedge clk);
      check("idle.busy_a", 32'(busy_a), 32'h0);

      // 0xA5, parity on (mode 1), good parity bit
      send_frame(0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
      hold(0, 1'b1, 4);
      compare_events(0, "t1");
      @(negedge clk);
      check("t1.hold", 32'(dout_a), 32'hA5);
      check("t1.busy", 32'(busy_a), 32'h0);

      // back-to-back frames, no idle gap
      send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
      hold(0, 1'b1, 4);
      compare_events(0, "t2");

      // wrong parity bit
      send_frame(0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
      hold(0, 1'b1, 4);
      compare_events(0, "t3");

      // stop bit 0 followed by a held-low line
      send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(0, 1'b0);
         @(negedge clk);
         check($sformatf("t4.brk%0d", i), 32'(busy_a), 32'h1);
      end
      drive(0, 1'b1);
      @(negedge clk);
      check("t4.exit", 32'(busy_a), 32'h1);
      hold(0, 1'b1, LAT + 1);
      @(negedge clk);
      check("t4.idle", 32'(busy_a), 32'h0);
      hold(0, 1'b1, 6);
      compare_events(0, "t4");

      // 16 clocks/bit: 3-cycle low glitch is rejected at the mid-bit start check
      for (int i = 0; i < 12; i++) begin
         drive(1, (i < 3) ? 1'b0 : 1'b1);
         @(negedge clk);
         if (i == 2 + LAT) check("t5.busy", 32'(busy_b), 32'h1);
         if (i == 8 + LAT) check("t5.idle", 32'(busy_b), 32'h0);
      end
      hold(1, 1'b1, 4);
      compare_events(1, "t5.glitch");
      send_frame(1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
      hold(1, 1'b1, 4);
      compare_events(1, "t5");
      @(negedge clk);
      check("t5.dout", 32'(dout_b), 32'h81);

      // random frames, occasional bad stop bit, random gaps
      for (int i = 0; i < 10; i++) begin
         d  = 8'($urandom);
         pe = 1'($urandom_range(0, 1));
         ep = 1'($urandom_range(0, 1));
         pb = 1'($urandom_range(0, 1));
         st = ($urandom_range(0, 3) != 0);
         send_frame(0, d, pe, ep, pb, st);
         gap = st ? $urandom_range(0, 3) : $urandom_range(1, 3);
         hold(0, 1'b1, gap);
      end
      hold(0, 1'b1, 4);
      compare_events(0, "rnd_a");
      for (int i = 0; i < 4; i++) begin
         d  = 8'($urandom);
         pe = 1'($urandom_range(0, 1));
         ep = 1'($urandom_range(0, 1));
         pb = 1'($urandom_range(0, 1));
         st = ($urandom_range(0, 3) != 0);
         send_frame(1, d, pe, ep, pb, st);
         gap = st ? $urandom_range(0, 3) : $urandom_range(1, 3);
         hold(1, 1'b1, gap);
      end
      hold(1, 1'b1, 4);
      compare_events(1, "rnd_b");

      // reset one cycle after data bit 3 of a frame
      part = 8'h12;
      parity_en = 1'b0;
      drive(0, 1'b0);
      for (int b = 0; b < 4; b++) drive(0, part[b]);
      @(posedge clk);
      #1 rst = 1'b1; rx_a = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0; rx_a = 1'b1;
      @(negedge clk);
      check("t6.valid", 32'(valid_a), 32'h0);
      check("t6.dout", 32'(dout_a), 32'h00);
      check("t6.perr", 32'(perr_a), 32'h0);
      check("t6.ferr", 32'(ferr_a), 32'h0);
      check("t6.busy", 32'(busy_a), 32'h0);
      hold(0, 1'b1, 12);
      compare_events(0, "t6.abort");
      send_frame(0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
      hold(0, 1'b1, 4);
      compare_events(0, "t6");
      @(negedge clk);
      check("t6.dout_new", 32'(dout_a), 32'h12);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
